flp_norm_round: RTL

//   Pipelined normalize/round/pack stage for the FLP_adder datapath. It takes the

---
 rtl/flp_norm_round.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/flp_norm_round.sv
// Normalize, round-to-nearest-even and pack a 28-bit extended sum into IEEE-754 single; 2-cycle latency, 1 beat/clk.
// Backpressure: stages advance only when the next one frees up, so in_ready drops when both stages hold and out_ready=0.
module flp_norm_round #(
  parameter int EXP_IN_W = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_sign,
  input  logic [EXP_IN_W-1:0] in_exp,
  input  logic [27:0]         in_mant,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         d,
  output logic                out_ovf,
  output logic                out_unf
);

  localparam int EW = EXP_IN_W + 1;
  typedef logic signed [EW-1:0] exp_t;

  localparam exp_t EXP_INF  = exp_t'(255);
  localparam exp_t EXP_ZERO = exp_t'(0);

  // Stage 1: normalized mantissa [26]=hidden, [25:3]=frac, [2]=G, [1]=R, [0]=S
  logic        s1_valid_q, s1_valid_d;
  logic        s1_sign_q,  s1_sign_d;
  exp_t        s1_exp_q,   s1_exp_d;
  logic [26:0] s1_mant_q,  s1_mant_d;

  // Stage 2 doubles as the output register
  logic        s2_valid_q, s2_valid_d;
  logic [31:0] d_q,        d_d;
  logic        ovf_q,      ovf_d;
  logic        unf_q,      unf_d;

  logic        acc2;
  logic [4:0]  lz;
  exp_t        exp_ext;
  exp_t        norm_exp;
  logic [26:0] norm_mant;

  logic        s1_zero;
  logic [22:0] frac;
  logic        rnd_up;
  logic [23:0] frac_sum;
  exp_t        rnd_exp;
  logic [31:0] pk_d;
  logic        pk_ovf;
  logic        pk_unf;

  assign acc2      = !s2_valid_q || out_ready;
  assign in_ready  = !s1_valid_q || acc2;
  assign out_valid = s2_valid_q;
  assign d         = d_q;
  assign out_ovf   = ovf_q;
  assign out_unf   = unf_q;

  // Normalize
  always_comb begin
    lz = 5'd0;
    for (int i = 0; i < 27; i++) begin
      if (in_mant[i]) lz = 5'(26 - i);
    end
    exp_ext = {in_exp[EXP_IN_W-1], in_exp};
    if (in_mant[27]) begin
      norm_mant = {in_mant[27:2], in_mant[1] | in_mant[0]};
      norm_exp  = exp_ext + exp_t'(1);
    end else begin
      norm_mant = in_mant[26:0] << lz;
      norm_exp  = exp_ext - {{(EW-5){1'b0}}, lz};
    end
  end

  // Round and pack; a normalized non-zero mantissa always has the hidden bit
  // set, so a clear hidden bit is the zero flag.
  always_comb begin
    s1_zero  = !s1_mant_q[26];
    frac     = s1_mant_q[25:3];
    rnd_up   = s1_mant_q[2] & (s1_mant_q[1] | s1_mant_q[0] | frac[0]);
    frac_sum = {1'b0, frac} + {23'd0, rnd_up};
    rnd_exp  = s1_exp_q + {{(EW-1){1'b0}}, frac_sum[23]};
    pk_d     = 32'd0;
    pk_ovf   = 1'b0;
    pk_unf   = 1'b0;
    if (s1_zero) begin
      pk_d = 32'd0;
    end else if (rnd_exp >= EXP_INF) begin
      pk_d   = {s1_sign_q, 8'hFF, 23'd0};
      pk_ovf = 1'b1;
    end else if (rnd_exp <= EXP_ZERO) begin
      pk_d   = {s1_sign_q, 31'd0};
      pk_unf = 1'b1;
    end else begin
      pk_d = {s1_sign_q, rnd_exp[7:0], frac_sum[22:0]};
    end
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_sign_d  = s1_sign_q;
    s1_exp_d   = s1_exp_q;
    s1_mant_d  = s1_mant_q;
    s2_valid_d = s2_valid_q;
    d_d        = d_q;
    ovf_d      = ovf_q;
    unf_d      = unf_q;

    if (in_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_sign_d = in_sign;
        s1_exp_d  = norm_exp;
        s1_mant_d = norm_mant;
      end
    end

    if (acc2) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        d_d   = pk_d;
        ovf_d = pk_ovf;
        unf_d = pk_unf;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_exp_q   <= '0;
      s1_mant_q  <= '0;
      s2_valid_q <= 1'b0;
      d_q        <= '0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_sign_q  <= s1_sign_d;
      s1_exp_q   <= s1_exp_d;
      s1_mant_q  <= s1_mant_d;
      s2_valid_q <= s2_valid_d;
      d_q        <= d_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

endmodule
